// File: rtl/opcodes.sv
// Shared ALU/flags definitions: flag bit positions and branch condition codes.
// Also provides the condition evaluator used by the flags unit.
package opcodes;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAGS_Z = 0;
  localparam int unsigned FLAGS_N = 1;
  localparam int unsigned FLAGS_C = 2;
  localparam int unsigned FLAGS_V = 3;

  typedef enum logic [3:0] {
    CAL = 4'd0,
    CNV = 4'd1,
    CEQ = 4'd2,
    CNE = 4'd3,
    CCS = 4'd4,
    CCC = 4'd5,
    CMI = 4'd6,
    CPL = 4'd7,
    CVS = 4'd8,
    CVC = 4'd9,
    CHI = 4'd10,
    CLS = 4'd11,
    CGE = 4'd12,
    CLT = 4'd13,
    CGT = 4'd14,
    CLE = 4'd15
  } cond_t;

  function automatic logic cond_eval(input cond_t cond, input logic [FLAGS_W-1:0] flags);
    logic z, n, c, v, res;
    z   = flags[FLAGS_Z];
    n   = flags[FLAGS_N];
    c   = flags[FLAGS_C];
    v   = flags[FLAGS_V];
    res = 1'b0;
    unique case (cond)
      CAL: res = 1'b1;
      CNV: res = 1'b0;
      CEQ: res = z;
      CNE: res = !z;
      CCS: res = c;
      CCC: res = !c;
      CMI: res = n;
      CPL: res = !n;
      CVS: res = v;
      CVC: res = !v;
      CHI: res = c & !z;
      CLS: res = !c | z;
      CGE: res = (n == v);
      CLT: res = (n != v);
      CGT: res = !z & (n == v);
      CLE: res = z | (n != v);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Generic Depth x Width LIFO with sticky error on overflow, underflow or
// simultaneous push/pop. Contents are not reset; they are unreadable while empty.
module flag_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4,
  localparam int unsigned SpW  = $clog2(Depth + 1),
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             err_clr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             pop_ok_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam logic [SpW-1:0] SpMax = SpW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [SpW-1:0]   sp_q, sp_d, sp_dec;
  logic [IdxW-1:0]  wr_idx, rd_idx;
  logic             err_q, err_d;
  logic             push_ok, pop_ok, err_evt;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SpMax);

  assign push_ok = push_i & ~pop_i & ~full_o;
  assign pop_ok  = pop_i & ~push_i & ~empty_o;
  assign err_evt = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);

  assign sp_dec = sp_q - SpW'(1);
  assign wr_idx = sp_q[IdxW-1:0];
  assign rd_idx = sp_dec[IdxW-1:0];

  assign rdata_o  = mem_q[rd_idx];
  assign pop_ok_o = pop_ok;
  assign err_o    = err_q;

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop_ok) begin
      sp_d = sp_dec;
    end
  end

  // A new error in the same cycle as a clear must remain visible.
  always_comb begin
    err_d = err_q;
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/flags_unit.sv
// ALU flag register with carry feedback, branch condition decode and a small
// flag save/restore stack for interrupt entry and return.
module flags_unit
  import opcodes::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH + 1)
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic [FLAGS_W-1:0] AluFlags,
  input  logic               FlagsWe,
  input  logic               Push,
  input  logic               Pop,
  input  logic               ErrClr,
  input  cond_t              Cond,
  output logic [FLAGS_W-1:0] Flags,
  output logic               CarryOut,
  output logic               CondTrue,
  output logic               StackEmpty,
  output logic               StackFull,
  output logic               StackErr
);

  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic [FLAGS_W-1:0] stack_rdata;
  logic               stack_pop_ok;

  // The stack always captures the pre-edge flags, so a same-cycle FlagsWe
  // cannot leak into the saved copy.
  flag_stack #(
    .Depth (DEPTH),
    .Width (FLAGS_W)
  ) u_flag_stack (
    .clk_i     (Clock),
    .rst_ni    (nReset),
    .push_i    (Push),
    .pop_i     (Pop),
    .err_clr_i (ErrClr),
    .wdata_i   (flags_q),
    .rdata_o   (stack_rdata),
    .pop_ok_o  (stack_pop_ok),
    .empty_o   (StackEmpty),
    .full_o    (StackFull),
    .err_o     (StackErr)
  );

  // A successful restore overrides the ALU write; a rejected pop does not.
  always_comb begin
    flags_d = flags_q;
    if (stack_pop_ok) begin
      flags_d = stack_rdata;
    end else if (FlagsWe) begin
      flags_d = AluFlags;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign Flags    = flags_q;
  assign CarryOut = flags_q[FLAGS_C];
  assign CondTrue = cond_eval(Cond, flags_q);

endmodule

// File: tb/tb_flags_unit.sv
// Directed bench for flags_unit: the driver queues expected outputs, an
// independent monitor pops and compares them 2 time units after each falling edge.
module tb_flags_unit;
  import opcodes::*;

  localparam int SelFlags = 0;
  localparam int SelCarry = 1;
  localparam int SelCond  = 2;
  localparam int SelEmpty = 3;
  localparam int SelFull  = 4;
  localparam int SelErr   = 5;

  typedef struct {
    string      name;
    int         sel;
    logic [3:0] val;
  } exp_t;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [3:0] AluFlags;
  logic       FlagsWe, Push, Pop, ErrClr;
  cond_t      Cond;
  logic [3:0] Flags;
  logic       CarryOut, CondTrue, StackEmpty, StackFull, StackErr;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  flags_unit #(
    .DEPTH (4)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .AluFlags   (AluFlags),
    .FlagsWe    (FlagsWe),
    .Push       (Push),
    .Pop        (Pop),
    .ErrClr     (ErrClr),
    .Cond       (Cond),
    .Flags      (Flags),
    .CarryOut   (CarryOut),
    .CondTrue   (CondTrue),
    .StackEmpty (StackEmpty),
    .StackFull  (StackFull),
    .StackErr   (StackErr)
  );

  always #5 Clock = ~Clock;

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      SelFlags: return Flags;
      SelCarry: return {3'b0, CarryOut};
      SelCond:  return {3'b0, CondTrue};
      SelEmpty: return {3'b0, StackEmpty};
      SelFull:  return {3'b0, StackFull};
      default:  return {3'b0, StackErr};
    endcase
  endfunction

  // Monitor: checks everything queued for the current cycle.
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(negedge Clock);
      #2;
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [3:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [3:0] alu, input logic push,
                       input logic pop, input logic clr, input cond_t c);
    @(negedge Clock);
    FlagsWe  = we;
    AluFlags = alu;
    Push     = push;
    Pop      = pop;
    ErrClr   = clr;
    Cond     = c;
  endtask

  task automatic idle(input cond_t c);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, c);
  endtask

  initial begin
    nReset   = 1'b0;
    FlagsWe  = 1'b0;
    AluFlags = 4'h0;
    Push     = 1'b0;
    Pop      = 1'b0;
    ErrClr   = 1'b0;
    Cond     = CAL;

    // Reset state
    idle(CAL);
    expect_out("rst_flags", SelFlags, 4'h0);
    expect_out("rst_carry", SelCarry, 4'h0);
    expect_out("rst_empty", SelEmpty, 4'h1);
    expect_out("rst_full",  SelFull,  4'h0);
    expect_out("rst_err",   SelErr,   4'h0);
    expect_out("rst_cal",   SelCond,  4'h1);
    idle(CNV);
    expect_out("rst_cnv", SelCond, 4'h0);
    nReset = 1'b1;

    // Load Z|C and evaluate unsigned conditions
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, CAL);
    idle(CEQ);
    expect_out("load_flags", SelFlags, 4'h5);
    expect_out("load_carry", SelCarry, 4'h1);
    expect_out("ceq_zc", SelCond, 4'h1);
    idle(CHI);
    expect_out("chi_zc", SelCond, 4'h0);
    idle(CLS);
    expect_out("cls_zc", SelCond, 4'h1);
    idle(CNE);
    expect_out("cne_zc", SelCond, 4'h0);
    expect_out("hold_flags", SelFlags, 4'h5);

    // Signed conditions: N=1, V=0
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, CAL);
    idle(CLT);
    expect_out("n_flags", SelFlags, 4'h2);
    expect_out("n_carry", SelCarry, 4'h0);
    expect_out("clt_n", SelCond, 4'h1);
    idle(CGE);
    expect_out("cge_n", SelCond, 4'h0);
    idle(CGT);
    expect_out("cgt_n", SelCond, 4'h0);
    idle(CLE);
    expect_out("cle_n", SelCond, 4'h1);
    // N=0, Z=0, C=1
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, CAL);
    idle(CGT);
    expect_out("cgt_c", SelCond, 4'h1);
    idle(CHI);
    expect_out("chi_c", SelCond, 4'h1);

    // Stack fill with 1,2,4,8
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(1 << i), 1'b0, 1'b0, 1'b0, CAL);
      drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    end
    idle(CAL);
    expect_out("fill_full",  SelFull,  4'h1);
    expect_out("fill_empty", SelEmpty, 4'h0);
    expect_out("fill_err",   SelErr,   4'h0);
    expect_out("fill_flags", SelFlags, 4'h8);
    // Overflow push
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    idle(CAL);
    expect_out("ovf_err",  SelErr,  4'h1);
    expect_out("ovf_full", SelFull, 4'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, CAL);
    idle(CAL);
    expect_out("clr_err", SelErr, 4'h0);
    // Drain
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, CAL);
      idle(CAL);
      expect_out($sformatf("pop%0d_flags", i), SelFlags, 4'(1 << i));
      expect_out($sformatf("pop%0d_full", i), SelFull, 4'h0);
    end
    expect_out("drain_empty", SelEmpty, 4'h1);
    expect_out("drain_err",   SelErr,   4'h0);

    // Pop beats FlagsWe
    drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, CAL);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, CAL);
    drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("popwe_flags", SelFlags, 4'h6);
    expect_out("popwe_empty", SelEmpty, 4'h1);
    expect_out("popwe_err",   SelErr,   4'h0);

    // Push with FlagsWe stacks the old value
    drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, CAL);
    idle(CAL);
    expect_out("pushwe_flags", SelFlags, 4'h9);
    expect_out("pushwe_empty", SelEmpty, 4'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("pushwe_stacked", SelFlags, 4'h6);
    expect_out("pushwe_empty2",  SelEmpty, 4'h1);

    // Push and Pop together
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, CAL);
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("pp_flags", SelFlags, 4'hA);
    expect_out("pp_empty", SelEmpty, 4'h0);
    expect_out("pp_full",  SelFull,  4'h0);
    expect_out("pp_err",   SelErr,   4'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("pp_pop_flags", SelFlags, 4'h6);
    expect_out("pp_pop_empty", SelEmpty, 4'h1);

    // Underflow and clear
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, CAL);
    idle(CAL);
    expect_out("clr2_err", SelErr, 4'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("unf_flags", SelFlags, 4'h6);
    expect_out("unf_err",   SelErr,   4'h1);
    drive(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("unf_we_flags", SelFlags, 4'hC);
    expect_out("unf_we_empty", SelEmpty, 4'h1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, CAL);
    idle(CAL);
    expect_out("clr3_err", SelErr, 4'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, CAL);
    idle(CAL);
    expect_out("clr_vs_err", SelErr, 4'h1);

    // Asynchronous reset mid-operation after two pushes
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, CAL);
    idle(CEQ);
    expect_out("pre_rst_empty", SelEmpty, 4'h0);
    @(negedge Clock);
    #1;
    nReset = 1'b0;
    expect_out("arst_flags", SelFlags, 4'h0);
    expect_out("arst_empty", SelEmpty, 4'h1);
    expect_out("arst_err",   SelErr,   4'h0);
    expect_out("arst_ceq",   SelCond,  4'h0);
    idle(CAL);
    nReset = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, CAL);
    idle(CAL);
    expect_out("post_rst_unf", SelErr, 4'h1);
    expect_out("post_rst_flags", SelFlags, 4'h0);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge Clock);
    #3;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
